// File: rtl/adsr_poly.sv
// Time-multiplexed ADSR envelope for 2^VOICE_BITS voices; scales each voice's sample by its new level.
// Latency 2 cycles, one slot per cycle, no backpressure (in_valid only qualifies the slot).
module adsr_poly #(
  parameter int VOICE_BITS = 8,
  parameter int SAMPLE_W   = 16,
  parameter int ENV_W      = 16,
  parameter bit RETRIGGER  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [VOICE_BITS-1:0]      voice_index,
  input  logic                       key_state,
  input  logic [ENV_W-1:0]           attack_amt,
  input  logic [ENV_W-1:0]           decay_amt,
  input  logic [ENV_W-1:0]           sustain_amt,
  input  logic [ENV_W-1:0]           rel_amt,
  input  logic signed [SAMPLE_W-1:0] input_sample,
  output logic                       out_valid,
  output logic [VOICE_BITS-1:0]      out_voice_index,
  output logic signed [SAMPLE_W-1:0] output_sample,
  output logic [ENV_W-1:0]           env_level,
  output logic                       voice_active
);

  localparam int VOICES = 1 << VOICE_BITS;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} phase_t;

  typedef struct packed {
    logic                  vld;
    logic [VOICE_BITS-1:0] voice;
    logic                  key;
    logic [ENV_W-1:0]      att;
    logic [ENV_W-1:0]      dec;
    logic [ENV_W-1:0]      sus;
    logic [ENV_W-1:0]      rel;
    logic [SAMPLE_W-1:0]   dat;
  } slot_t;

  slot_t                s1;
  phase_t               phase_mem [VOICES];
  logic [ENV_W-1:0]     level_mem [VOICES];

  phase_t               cur_phase, nxt_phase;
  logic [ENV_W-1:0]     cur_level, nxt_level, att_base;
  logic [ENV_W:0]       att_sum, dec_floor;
  logic signed [SAMPLE_W+ENV_W-1:0] product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.vld   <= in_valid;
      s1.voice <= voice_index;
      s1.key   <= key_state;
      s1.att   <= attack_amt;
      s1.dec   <= decay_amt;
      s1.sus   <= sustain_amt;
      s1.rel   <= rel_amt;
      s1.dat   <= input_sample;
    end
  end

  // Envelope next-state: one step per valid slot, all clamps in ENV_W+1 bits.
  always_comb begin
    cur_phase = phase_mem[s1.voice];
    cur_level = level_mem[s1.voice];
    att_base  = (cur_phase == RELEASE && RETRIGGER) ? '0 : cur_level;
    att_sum   = {1'b0, att_base} + {1'b0, s1.att};
    dec_floor = {1'b0, s1.sus} + {1'b0, s1.dec};
    nxt_phase = cur_phase;
    nxt_level = cur_level;
    if (!s1.key) begin
      if (cur_phase != IDLE) begin
        if (s1.rel == '0 || cur_level <= s1.rel) begin
          nxt_level = '0;
          nxt_phase = IDLE;
        end else begin
          nxt_level = cur_level - s1.rel;
          nxt_phase = RELEASE;
        end
      end
    end else begin
      case (cur_phase)
        IDLE, ATTACK, RELEASE: begin
          if (s1.att == '0 || att_sum >= {1'b0, ENV_MAX}) begin
            nxt_level = ENV_MAX;
            nxt_phase = DECAY;
          end else begin
            nxt_level = att_sum[ENV_W-1:0];
            nxt_phase = ATTACK;
          end
        end
        DECAY: begin
          if (s1.dec == '0 || {1'b0, cur_level} <= dec_floor) begin
            nxt_level = s1.sus;
            nxt_phase = SUSTAIN;
          end else begin
            nxt_level = cur_level - s1.dec;
            nxt_phase = DECAY;
          end
        end
        SUSTAIN: nxt_level = s1.sus;
        default: begin
          nxt_level = '0;
          nxt_phase = IDLE;
        end
      endcase
    end
    product = $signed(s1.dat) * $signed({1'b0, nxt_level});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        phase_mem[i] <= IDLE;
        level_mem[i] <= '0;
      end
    end else if (s1.vld) begin
      phase_mem[s1.voice] <= nxt_phase;
      level_mem[s1.voice] <= nxt_level;
    end
  end

  // Outputs other than out_valid hold across idle slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid       <= 1'b0;
      out_voice_index <= '0;
      output_sample   <= '0;
      env_level       <= '0;
      voice_active    <= 1'b0;
    end else begin
      out_valid <= s1.vld;
      if (s1.vld) begin
        out_voice_index <= s1.voice;
        output_sample   <= SAMPLE_W'(product >>> ENV_W);
        env_level       <= nxt_level;
        voice_active    <= (nxt_phase != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_adsr_poly.sv
// Scoreboard bench for adsr_poly: two instances (legato and retrigger) against an arithmetic envelope model.
module tb_adsr_poly;

  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
  localparam int LMAX = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  voice_index = '0;
  logic        key_state = 1'b0;
  logic [15:0] attack_amt = '0, decay_amt = '0, sustain_amt = '0, rel_amt = '0;
  logic signed [15:0] input_sample = '0;

  logic              o_vld [2];
  logic [7:0]        o_vi  [2];
  logic signed [15:0] o_smp [2];
  logic [15:0]       o_lvl [2];
  logic              o_act [2];

  typedef struct {
    int cyc;
    int voice;
    int smp;
    int lvl;
    int act;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m_ph [2][256];
  int   m_lv [2][256];
  int   last_vi [2], last_smp [2], last_lvl [2], last_act [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adsr_poly #(.VOICE_BITS(8), .SAMPLE_W(16), .ENV_W(16), .RETRIGGER(1'b0)) u_legato (
    .clk(clk), .reset(reset), .in_valid(in_valid), .voice_index(voice_index),
    .key_state(key_state), .attack_amt(attack_amt), .decay_amt(decay_amt),
    .sustain_amt(sustain_amt), .rel_amt(rel_amt), .input_sample(input_sample),
    .out_valid(o_vld[0]), .out_voice_index(o_vi[0]), .output_sample(o_smp[0]),
    .env_level(o_lvl[0]), .voice_active(o_act[0]));

  adsr_poly #(.VOICE_BITS(8), .SAMPLE_W(16), .ENV_W(16), .RETRIGGER(1'b1)) u_retrig (
    .clk(clk), .reset(reset), .in_valid(in_valid), .voice_index(voice_index),
    .key_state(key_state), .attack_amt(attack_amt), .decay_amt(decay_amt),
    .sustain_amt(sustain_amt), .rel_amt(rel_amt), .input_sample(input_sample),
    .out_valid(o_vld[1]), .out_voice_index(o_vi[1]), .output_sample(o_smp[1]),
    .env_level(o_lvl[1]), .voice_active(o_act[1]));

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Envelope rules written directly as clamped arithmetic on an integer level.
  task automatic model_step(input int i, input int v, input int key, input int a, input int d,
                            input int s, input int r, output int lvl, output int act);
    int ph, lv;
    ph = m_ph[i][v];
    lv = m_lv[i][v];
    if (key == 0) begin
      if (ph != P_IDLE) begin
        lv = (r == 0) ? 0 : ((lv - r < 0) ? 0 : lv - r);
        ph = (lv == 0) ? P_IDLE : P_REL;
      end
    end else if (ph == P_SUS) begin
      lv = s;
    end else if (ph == P_DEC) begin
      lv = (d == 0) ? s : ((lv - d < s) ? s : lv - d);
      ph = (lv == s) ? P_SUS : P_DEC;
    end else begin
      if (ph == P_REL && i == 1) lv = 0;
      lv = (a == 0) ? LMAX : ((lv + a > LMAX) ? LMAX : lv + a);
      ph = (lv == LMAX) ? P_DEC : P_ATT;
    end
    m_ph[i][v] = ph;
    m_lv[i][v] = lv;
    lvl = lv;
    act = (ph != P_IDLE) ? 1 : 0;
  endtask

  task automatic slot(input int vld, input int v, input int key, input int a, input int d,
                      input int s, input int r, input int smp);
    exp_t e;
    int   lv, act;
    @(posedge clk);
    #1;
    in_valid     = (vld != 0);
    voice_index  = 8'(v);
    key_state    = (key != 0);
    attack_amt   = 16'(a);
    decay_amt    = 16'(d);
    sustain_amt  = 16'(s);
    rel_amt      = 16'(r);
    input_sample = 16'(smp);
    if (vld != 0) begin
      for (int i = 0; i < 2; i++) begin
        model_step(i, v, key, a, d, s, r, lv, act);
        e.cyc   = cyc + 2;
        e.voice = v;
        e.lvl   = lv;
        e.act   = act;
        e.smp   = int'((longint'(smp) * longint'(lv)) >>> 16);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  endtask

  task automatic drain();
    repeat (2) slot(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_amt();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return int'($urandom_range(30000, 65535));
      default: return int'($urandom_range(1, 3000));
    endcase
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      last_vi[i] = 0; last_smp[i] = 0; last_lvl[i] = 0; last_act[i] = 0;
      for (int v = 0; v < 256; v++) begin
        m_ph[i][v] = P_IDLE;
        m_lv[i][v] = 0;
      end
    end
  endtask

  // Monitor: pops an expectation whenever out_valid shows; otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (o_vld[i]) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk($sformatf("spurious_out_valid[%0d]", i), 1, 0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("latency[%0d]", i), cyc, e.cyc);
            chk($sformatf("voice[%0d]", i), o_vi[i], e.voice);
            chk($sformatf("env_level[%0d] v%0d", i, e.voice), o_lvl[i], e.lvl);
            chk($sformatf("output_sample[%0d] v%0d", i, e.voice), o_smp[i], e.smp);
            chk($sformatf("voice_active[%0d] v%0d", i, e.voice), o_act[i], e.act);
            last_vi[i] = e.voice; last_smp[i] = e.smp; last_lvl[i] = e.lvl; last_act[i] = e.act;
          end
        end else begin
          chk($sformatf("hold_level[%0d]", i), o_lvl[i], last_lvl[i]);
          chk($sformatf("hold_sample[%0d]", i), o_smp[i], last_smp[i]);
          chk($sformatf("hold_voice[%0d]", i), o_vi[i], last_vi[i]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_out_valid", o_vld[i], 0);
      chk("reset_voice", o_vi[i], 0);
      chk("reset_sample", o_smp[i], 0);
      chk("reset_level", o_lvl[i], 0);
      chk("reset_active", o_act[i], 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Voice 3: attack by 400 saturates on slot 164.
    slot(1, 3, 1, 400, 200, 20000, 100, 1000);
    drain();
    chk("attack_first", o_lvl[0], 400);
    for (int n = 2; n <= 164; n++) slot(1, 3, 1, 400, 200, 20000, 100, rnd_smp());
    drain();
    chk("attack_saturate", o_lvl[0], 65535);
    slot(1, 3, 1, 400, 200, 20000, 100, rnd_smp());
    drain();
    chk("decay_first", o_lvl[0], 65335);
    for (int n = 0; n < 230; n++) slot(1, 3, 1, 400, 200, 20000, 100, rnd_smp());
    drain();
    chk("decay_clamp", o_lvl[0], 20000);
    slot(1, 3, 1, 400, 200, 30000, 100, rnd_smp());
    drain();
    chk("sustain_track", o_lvl[0], 30000);
    slot(1, 3, 1, 400, 200, 20000, 100, rnd_smp());
    for (int n = 0; n < 200; n++) slot(1, 3, 0, 400, 200, 20000, 100, 12345);
    drain();
    chk("release_zero_level", o_lvl[0], 0);
    chk("release_zero_active", o_act[0], 0);
    chk("release_zero_sample", o_smp[0], 0);

    // Voice 5: instant rates, then key-on mid-release at 5000.
    slot(1, 5, 1, 0, 0, 5100, 0, rnd_smp());
    drain();
    chk("instant_attack", o_lvl[0], 65535);
    slot(1, 5, 1, 0, 0, 5100, 0, rnd_smp());
    slot(1, 5, 0, 0, 0, 5100, 100, rnd_smp());
    drain();
    chk("release_5000", o_lvl[0], 5000);
    slot(1, 5, 1, 400, 0, 5100, 100, rnd_smp());
    drain();
    chk("legato_retrig", o_lvl[0], 5400);
    chk("hard_retrig", o_lvl[1], 400);
    slot(1, 5, 0, 400, 0, 5100, 0, rnd_smp());
    drain();
    chk("instant_release", o_lvl[0], 0);
    chk("instant_release_active", o_act[1], 0);

    // Scaling corner cases.
    slot(1, 9, 1, 0, 0, 0, 0, -32768);
    drain();
    chk("scale_full_neg", o_smp[0], -32768);
    slot(1, 10, 1, 32768, 0, 0, 0, 1000);
    drain();
    chk("scale_half", o_smp[0], 500);

    // Sweep all voices with gaps; only voice 7 keyed.
    for (int v = 0; v < 256; v++) begin
      slot(1, v, (v == 7) ? 1 : 0, 300, 50, 10000, 20, rnd_smp());
      slot(0, v, 1, 0, 0, 0, 0, rnd_smp());
    end

    // Random traffic concentrated on a few voices.
    for (int n = 0; n < 2000; n++) begin
      slot(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0) ? 1 : 0, rnd_amt(), rnd_amt(),
           int'($urandom_range(0, 65535)), rnd_amt(), rnd_smp());
    end

    // Mid-stream reset discards in-flight slots and voice state.
    drain();
    slot(1, 3, 1, 500, 0, 0, 0, rnd_smp());
    slot(1, 4, 1, 500, 0, 0, 0, rnd_smp());
    @(posedge clk);
    #1 reset = 1'b1;
    clear_model();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", o_vld[0], 0);
    chk("midreset_level", o_lvl[1], 0);
    reset = 1'b0;
    slot(1, 3, 1, 100, 0, 0, 0, 2000);
    drain();
    chk("post_reset_level", o_lvl[0], 100);
    chk("post_reset_level_rt", o_lvl[1], 100);

    drain();
    chk("queue0_empty", q0.size(), 0);
    chk("queue1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
